ped_request_debounce: RTL and testbench
=======================================

Name: ped_request_debounce

Overview:
- Upstream input-conditioning stage for the traffic-light controller.
- Takes raw pedestrian push-button pins, synchronises and debounces them, and produces a one-cycle press strobe per button.
- Holds a sticky request per button until the controller acknowledges it.
- Runs on the system clock; debounce timing is paced by the 1 kHz tick strobe already generated in the top level.

Parameters:
- NUM_BTN, 2, number of independent button channels.
- DEBOUNCE_TICKS, 20, consecutive ticks a changed level must persist before it is accepted (20 ms at 1 kHz).
- CNT_W, 5, debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_TICKS.
- LONG_TICKS, 1000, stable-high duration for a long press; used only with PED_REQ_LONGPRESS_EN.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, reset, asynchronous, active-low.
- tick_en, input, 1, one-clk-wide 1 kHz pacing strobe.
- btn_raw, input, NUM_BTN, asynchronous raw button pins, active-high.
- req_ack, input, NUM_BTN, controller acknowledge per channel, sampled each clk.
- btn_level, output, NUM_BTN, debounced stable level.
- btn_press, output, NUM_BTN, one-clk pulse on debounced rising edge.
- req_pending, output, NUM_BTN, sticky pedestrian request.
- long_press, output, NUM_BTN, one-clk pulse when a long press is detected.

Behaviour:
- Interface fixed: single clock clk; reset rst_n is asynchronous and active-low.
- Reset: synchroniser flops, stable level, counters and the request latch are all cleared. All outputs are 0.
- Synchroniser: 2-FF per bit. A raw edge is visible as synced at clk edge 2 after sampling.
- Per-channel debounce FSM, two states:
  - STABLE: synced == stable; counter held at 0.
  - CHANGING: synced != stable; counter increments on each tick_en.
- Entering CHANGING: counter starts at 0.
- Leaving CHANGING without acceptance: if synced returns to equal stable on any clk, the FSM goes back to STABLE and the counter clears to 0 the same clk (glitch rejection).
- Acceptance: on tick_en with counter == DEBOUNCE_TICKS-1, stable <= synced and counter <= 0. The next clk is STABLE.
- Counter saturates and never wraps. Ticks arriving while in STABLE are ignored.
- btn_press: asserted for exactly the clk after stable goes 0->1. A debounced release produces no pulse.
- req_pending:
  - set when btn_press = 1; cleared when req_ack = 1 and btn_press = 0.
  - If btn_press and req_ack are high in the same clk, the request stays set (a new press wins).
  - req_ack while not pending has no effect.
  - A held ack does not block later presses beyond that same-clk rule.
- Channels are fully independent; there is no cross-channel priority.
- Reset asserted mid-debounce discards the partial count. After release, raw inputs that are already high need the full sync plus debounce time before btn_press fires.

Optional Feature:
- PED_REQ_LONGPRESS_EN defined:
  - per-channel hold counter, width $clog2(LONG_TICKS+1), counts tick_en while stable = 1.
  - when it reaches LONG_TICKS-1 on a tick, long_press pulses for one clk and the counter saturates; no repeat until stable returns to 0.
  - the counter clears when stable = 0.
- PED_REQ_LONGPRESS_EN undefined: no hold counters are generated and long_press is tied to 0.

Decomposition:
- Package ped_req_pkg:
  - default DEBOUNCE_TICKS and LONG_TICKS constants.
  - debounce state enum {ST_STABLE, ST_CHANGING}.
- Sub-module btn_debounce_ch: one channel (sync, FSM, counter, press edge, optional hold counter), instantiated NUM_BTN times by generate.
- The request latch array stays in the parent.

Test Plan (DEBOUNCE_TICKS=4, LONG_TICKS=8, tick_en every 4 clk):
1. Reset behaviour: rst_n low with btn_raw=2'b11 -> all outputs 0. After release, btn_press[0] pulses once no earlier than 2 + 4 ticks; req_pending = 2'b11.
2. Glitch rejection: btn_raw[0] high for 3 ticks then low -> btn_level[0] stays 0, no btn_press, counter observed back at 0.
3. Press then ack: clean press on ch1 -> btn_press[1] is exactly 1 clk wide and req_pending[1]=1. req_ack[1] pulse -> req_pending[1]=0 next clk. Ch0 unaffected throughout.
4. Simultaneous press and ack: req_ack[0]=1 held during the btn_press[0] clk -> req_pending[0] remains 1. Releasing ack and asserting it again -> clears.
5. Async reset mid-debounce: rst_n low during tick 2 of a press -> outputs 0 immediately, without waiting for a clk edge. After release, a full 4-tick debounce is required.
6. PED_REQ_LONGPRESS_EN defined: hold ch0 -> long_press[0] pulses once, 8 ticks after btn_level rises, with no repeat. With the macro undefined, long_press stays 0.

Source files
------------

// File: rtl/ped_req_pkg.sv
// Shared constants and types for the pedestrian push-button conditioning stage.
package ped_req_pkg;

  localparam int DEBOUNCE_TICKS_DEF = 20;
  localparam int LONG_TICKS_DEF     = 1000;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_CHANGING = 1'b1
  } db_state_e;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, tick-paced debounce FSM, press edge detect
// and, when PED_REQ_LONGPRESS_EN is defined, a long-press hold counter.
//
// state       | meaning
// ST_STABLE   | synced level matches accepted level; counter held at 0
// ST_CHANGING | synced level differs; counting ticks towards acceptance
module btn_debounce_ch
  import ped_req_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF,
  parameter int CNT_W          = 5,
  parameter int LONG_TICKS     = LONG_TICKS_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_en,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic long_press
);

  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [1:0]       sync_q;
  logic             synced;
  db_state_e        state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             stable_q, stable_nxt;
  logic             stable_prev_q;

  assign synced = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q        <= 2'b00;
      state_q       <= ST_STABLE;
      cnt_q         <= '0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
    end else begin
      sync_q        <= {sync_q[0], btn_raw};
      state_q       <= state_nxt;
      cnt_q         <= cnt_nxt;
      stable_q      <= stable_nxt;
      stable_prev_q <= stable_q;
    end
  end

  always_comb begin
    state_nxt  = state_q;
    cnt_nxt    = cnt_q;
    stable_nxt = stable_q;
    case (state_q)
      ST_STABLE: begin
        cnt_nxt = '0;
        if (synced != stable_q) state_nxt = ST_CHANGING;
      end
      ST_CHANGING: begin
        // A return to the accepted level before acceptance is a glitch.
        if (synced == stable_q) begin
          state_nxt = ST_STABLE;
          cnt_nxt   = '0;
        end else if (tick_en) begin
          if (cnt_q == CNT_TERM) begin
            stable_nxt = synced;
            cnt_nxt    = '0;
            state_nxt  = ST_STABLE;
          end else if (cnt_q != CNT_MAX) begin
            cnt_nxt = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = ST_STABLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign btn_level = stable_q;
  assign btn_press = stable_q & ~stable_prev_q;

`ifdef PED_REQ_LONGPRESS_EN
  localparam int HOLD_W = $clog2(LONG_TICKS + 1);
  localparam logic [HOLD_W-1:0] HOLD_TERM = HOLD_W'(LONG_TICKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_TICKS);

  logic [HOLD_W-1:0] hold_q;
  logic              long_q;

  // Saturating past the terminal count is what suppresses repeats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      long_q <= 1'b0;
      if (!stable_q) begin
        hold_q <= '0;
      end else if (tick_en) begin
        if (hold_q == HOLD_TERM) begin
          long_q <= 1'b1;
          hold_q <= HOLD_SAT;
        end else if (hold_q < HOLD_TERM) begin
          hold_q <= hold_q + 1'b1;
        end
      end
    end
  end

  assign long_press = long_q;
`else
  logic cfg_unused;
  assign cfg_unused = (LONG_TICKS > 0);
  assign long_press = 1'b0;
`endif

endmodule

// File: rtl/ped_request_debounce.sv
// Pedestrian button conditioning: per-channel debounce plus sticky request latch.
// Optional long-press detection is built when PED_REQ_LONGPRESS_EN is defined.
module ped_request_debounce
  import ped_req_pkg::*;
#(
  parameter int NUM_BTN        = 2,
  parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF,
  parameter int CNT_W          = 5,
  parameter int LONG_TICKS     = LONG_TICKS_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_en,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic [NUM_BTN-1:0] req_ack,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] req_pending,
  output logic [NUM_BTN-1:0] long_press
);

  logic [NUM_BTN-1:0] req_q;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
      .CNT_W         (CNT_W),
      .LONG_TICKS    (LONG_TICKS)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick_en   (tick_en),
      .btn_raw   (btn_raw[i]),
      .btn_level (btn_level[i]),
      .btn_press (btn_press[i]),
      .long_press(long_press[i])
    );
  end

  // A press in the same clk as an ack keeps the request set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= '0;
    end else begin
      req_q <= btn_press | (req_q & ~req_ack);
    end
  end

  assign req_pending = req_q;

endmodule

// File: tb/tb_ped_request_debounce.sv
// Scoreboard bench for ped_request_debounce: stimulus queues expected press windows,
// a negedge monitor pops and checks them along with long-press pulses.
module tb_ped_request_debounce;

  localparam int NB = 2;
`ifdef PED_REQ_LONGPRESS_EN
  localparam int EXP_LONG = 1;
`else
  localparam int EXP_LONG = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick_en = 1'b0;
  logic [NB-1:0] btn_raw = '0;
  logic [NB-1:0] req_ack = '0;
  logic [NB-1:0] btn_level, btn_press, req_pending, long_press;

  ped_request_debounce #(
    .NUM_BTN(NB), .DEBOUNCE_TICKS(4), .CNT_W(3), .LONG_TICKS(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick_en(tick_en), .btn_raw(btn_raw),
    .req_ack(req_ack), .btn_level(btn_level), .btn_press(btn_press),
    .req_pending(req_pending), .long_press(long_press)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tdiv = 0;
  initial forever begin
    @(negedge clk);
    tick_en = (tdiv == 3);
    tdiv = (tdiv + 1) % 4;
  end

  typedef struct {
    int ch;
    int lo;
    int hi;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   last_press[NB];
  int   long_seen[NB];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Press must land 16..20 clk after the raw edge / reset release at cycle cyc.
  task automatic push_exp(input int ch);
    exp_t e;
    e.ch = ch;
    e.lo = cyc + 16;
    e.hi = cyc + 20;
    exp_q.push_back(e);
  endtask

  initial begin
    logic [NB-1:0] prev_press;
    exp_t e;
    prev_press = '0;
    for (int b = 0; b < NB; b++) begin
      last_press[b] = 0;
      long_seen[b]  = 0;
    end
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_press = '0;
      end else begin
        for (int b = 0; b < NB; b++) begin
          if (prev_press[b]) begin
            check($sformatf("press_width_ch%0d", b), 32'(btn_press[b]), 32'd0);
            check($sformatf("req_set_after_press_ch%0d", b), 32'(req_pending[b]), 32'd1);
          end else if (btn_press[b]) begin
            last_press[b] = cyc;
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL press_unexpected ch=%0d actual=pulse@%0d required=none", b, cyc);
            end else begin
              e = exp_q.pop_front();
              check("press_channel", 32'(b), 32'(e.ch));
              checks++;
              if (cyc < e.lo || cyc > e.hi) begin
                failures++;
                $display("FAIL press_time ch=%0d actual=%0d required=%0d..%0d", b, cyc, e.lo, e.hi);
              end
            end
          end
          if (long_press[b]) begin
            long_seen[b]++;
            checks++;
`ifdef PED_REQ_LONGPRESS_EN
            if (cyc < last_press[b] + 29 || cyc > last_press[b] + 32) begin
              failures++;
              $display("FAIL long_time ch=%0d actual=%0d required=%0d..%0d", b, cyc,
                       last_press[b] + 29, last_press[b] + 32);
            end
`else
            failures++;
            $display("FAIL long_unexpected ch=%0d actual=pulse required=none", b);
`endif
          end
        end
        prev_press = btn_press;
      end
    end
  end

  initial begin
    int ls0, ls1;
    bit seen;

    // Reset with both buttons already held
    btn_raw = 2'b11;
    wait_clk(3);
    check("rst_level", 32'(btn_level), 32'd0);
    check("rst_press", 32'(btn_press), 32'd0);
    check("rst_req", 32'(req_pending), 32'd0);
    check("rst_long", 32'(long_press), 32'd0);
    push_exp(0);
    push_exp(1);
    rst_n = 1'b1;
    wait_clk(26);
    check("t1_level", 32'(btn_level), 32'h3);
    check("t1_req", 32'(req_pending), 32'h3);
    check("t1_queue_drained", 32'(exp_q.size()), 32'd0);

    btn_raw = 2'b00;
    wait_clk(26);
    check("release_level", 32'(btn_level), 32'd0);
    check("release_no_clear", 32'(req_pending), 32'h3);
    req_ack = 2'b11;
    wait_clk(1);
    req_ack = 2'b00;
    check("ack_both_clears", 32'(req_pending), 32'd0);

    // Glitch rejection on ch0
    btn_raw[0] = 1'b1;
    wait_clk(10);
    check("glitch_cnt_running", 32'(dut.g_ch[0].u_ch.cnt_q != 0), 32'd1);
    wait_clk(2);
    btn_raw[0] = 1'b0;
    wait_clk(8);
    check("glitch_level", 32'(btn_level), 32'd0);
    check("glitch_cnt_cleared", 32'(dut.g_ch[0].u_ch.cnt_q), 32'd0);
    check("glitch_req", 32'(req_pending), 32'd0);

    // Clean press on ch1 then ack
    push_exp(1);
    btn_raw[1] = 1'b1;
    wait_clk(26);
    check("t3_level", 32'(btn_level), 32'h2);
    check("t3_req", 32'(req_pending), 32'h2);
    req_ack[1] = 1'b1;
    wait_clk(1);
    req_ack[1] = 1'b0;
    check("t3_ack_clears", 32'(req_pending), 32'd0);
    btn_raw[1] = 1'b0;
    wait_clk(26);
    check("t3_release", 32'(btn_level), 32'd0);

    // Ack held through the press clk on ch0
    req_ack[0] = 1'b1;
    wait_clk(3);
    check("ack_idle_no_effect", 32'(req_pending), 32'd0);
    push_exp(0);
    btn_raw[0] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (btn_press[0]) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL t4_press_timeout actual=none required=pulse");
    end
    @(negedge clk);
    req_ack[0] = 1'b0;
    @(negedge clk);
    check("t4_press_wins", 32'(req_pending[0]), 32'd1);
    req_ack[0] = 1'b1;
    wait_clk(1);
    req_ack[0] = 1'b0;
    check("t4_reack_clears", 32'(req_pending[0]), 32'd0);
    btn_raw[0] = 1'b0;
    wait_clk(26);

    // Async reset mid-debounce on ch0 while ch1 is latched
    push_exp(1);
    btn_raw = 2'b10;
    wait_clk(26);
    check("t5_pre_level", 32'(btn_level), 32'h2);
    check("t5_pre_req", 32'(req_pending), 32'h2);
    btn_raw = 2'b11;
    wait_clk(10);
    check("t5_cnt_running", 32'(dut.g_ch[0].u_ch.cnt_q != 0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_level", 32'(btn_level), 32'd0);
    check("t5_async_req", 32'(req_pending), 32'd0);
    check("t5_async_cnt", 32'(dut.g_ch[0].u_ch.cnt_q), 32'd0);
    wait_clk(3);
    ls0 = long_seen[0];
    ls1 = long_seen[1];
    push_exp(0);
    push_exp(1);
    rst_n = 1'b1;
    wait_clk(26);
    check("t5_post_level", 32'(btn_level), 32'h3);
    check("t5_post_req", 32'(req_pending), 32'h3);

    // Long press: hold both channels well past the long-press window
    wait_clk(80);
    check("t6_long_count_ch0", 32'(long_seen[0] - ls0), 32'(EXP_LONG));
    check("t6_long_count_ch1", 32'(long_seen[1] - ls1), 32'(EXP_LONG));

    btn_raw = 2'b00;
    wait_clk(26);
    check("final_level", 32'(btn_level), 32'd0);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
